rr_operand_stage: RTL and testbench

Register-read operand stage. It sits between the issue queue and execute, and surrounds the physical register file read ports. It latches issued instructions, drives the PRF read addresses, and merges PRF read data with same-cycle writeback bypass. It delivers complete operand packets to execute through a valid/ready handshake, with flush and stall accounting.

---
 rtl/rr_operand_stage.sv | 134 +++++++++++++
 tb/tb_rr_operand_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_operand_stage.sv
// Register-read operand stage: latches issue bundles, reads the PRF from stage A tags,
// resolves operands with same-cycle writeback bypass and hands packets to execute.
module rr_operand_stage #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned TAG_W  = 7,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PAY_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              issValid_i,
  input  logic [LANES*TAG_W-1:0]        issSrc1_i,
  input  logic [LANES*TAG_W-1:0]        issSrc2_i,
  input  logic [LANES*2-1:0]            issSrcVld_i,
  input  logic [LANES*PAY_W-1:0]        issPay_i,
  output logic                          issReady_o,
  output logic [2*LANES*TAG_W-1:0]      prfAddr_o,
  input  logic [2*LANES*DATA_W-1:0]     prfData_i,
  input  logic [LANES-1:0]              bypValid_i,
  input  logic [LANES*TAG_W-1:0]        bypTag_i,
  input  logic [LANES*DATA_W-1:0]       bypData_i,
  output logic [LANES-1:0]              exValid_o,
  output logic [LANES*DATA_W-1:0]       exSrc1_o,
  output logic [LANES*DATA_W-1:0]       exSrc2_o,
  output logic [LANES*PAY_W-1:0]        exPay_o,
  input  logic                          exReady_i,
  input  logic                          flush_i,
  output logic [15:0]                   stallCnt_o
);

  localparam int unsigned CNT_W = 16;

  // Stage A state
  logic [LANES-1:0]        valid_a;
  logic [LANES*TAG_W-1:0]  src1_a;
  logic [LANES*TAG_W-1:0]  src2_a;
  logic [LANES*2-1:0]      srcvld_a;
  logic [LANES*PAY_W-1:0]  pay_a;

  logic                    adv_b;
  logic [LANES*DATA_W-1:0] res1;
  logic [LANES*DATA_W-1:0] res2;

  assign adv_b      = ~|exValid_o | exReady_i;
  assign issReady_o = ~|valid_a | adv_b;

  // PRF read ports follow the stage A tags so a held bundle re-reads every cycle
  for (genvar i = 0; i < LANES; i++) begin : g_addr
    assign prfAddr_o[2*i*TAG_W +: TAG_W]     = src1_a[i*TAG_W +: TAG_W];
    assign prfAddr_o[(2*i+1)*TAG_W +: TAG_W] = src2_a[i*TAG_W +: TAG_W];
  end

  // Unused source -> 0; else lowest matching writeback lane; else PRF read data
  function automatic logic [DATA_W-1:0] resolve(
    input logic                      used,
    input logic [TAG_W-1:0]          tag,
    input logic [DATA_W-1:0]         prf,
    input logic [LANES-1:0]          bv,
    input logic [LANES*TAG_W-1:0]    bt,
    input logic [LANES*DATA_W-1:0]   bd
  );
    logic [DATA_W-1:0] r;
    logic              hit;
    r   = prf;
    hit = 1'b0;
    for (int j = 0; j < int'(LANES); j++) begin
      if (!hit && bv[j] && (bt[j*TAG_W +: TAG_W] == tag)) begin
        r   = bd[j*DATA_W +: DATA_W];
        hit = 1'b1;
      end
    end
    if (!used) r = '0;
    return r;
  endfunction

  always_comb begin
    res1 = '0;
    res2 = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      res1[i*DATA_W +: DATA_W] = resolve(srcvld_a[2*i], src1_a[i*TAG_W +: TAG_W],
                                         prfData_i[2*i*DATA_W +: DATA_W],
                                         bypValid_i, bypTag_i, bypData_i);
      res2[i*DATA_W +: DATA_W] = resolve(srcvld_a[2*i+1], src2_a[i*TAG_W +: TAG_W],
                                         prfData_i[(2*i+1)*DATA_W +: DATA_W],
                                         bypValid_i, bypTag_i, bypData_i);
    end
  end

  // Stage A: flush drops both held and presented bundles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_a  <= '0;
      src1_a   <= '0;
      src2_a   <= '0;
      srcvld_a <= '0;
      pay_a    <= '0;
    end else if (flush_i) begin
      valid_a  <= '0;
    end else if (issReady_o) begin
      valid_a  <= issValid_i;
      src1_a   <= issSrc1_i;
      src2_a   <= issSrc2_i;
      srcvld_a <= issSrcVld_i;
      pay_a    <= issPay_i;
    end
  end

  // Stage B: resolved operand packet presented to execute
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exValid_o <= '0;
      exSrc1_o  <= '0;
      exSrc2_o  <= '0;
      exPay_o   <= '0;
    end else if (flush_i) begin
      exValid_o <= '0;
    end else if (adv_b) begin
      exValid_o <= valid_a;
      exSrc1_o  <= res1;
      exSrc2_o  <= res2;
      exPay_o   <= pay_a;
    end
  end

  // Saturating stall counter; survives flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_o <= '0;
    end else if (|exValid_o && !exReady_i && (stallCnt_o != {CNT_W{1'b1}})) begin
      stallCnt_o <= stallCnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_operand_stage.sv
// Randomized and directed bench for rr_operand_stage against a bundle-level pipeline model.
module tb_rr_operand_stage;

  localparam int LANES  = 4;
  localparam int TAG_W  = 7;
  localparam int DATA_W = 64;
  localparam int PAY_W  = 32;
  localparam int NREG   = 1 << TAG_W;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic [LANES-1:0]            issValid_i = '0;
  logic [LANES*TAG_W-1:0]      issSrc1_i = '0;
  logic [LANES*TAG_W-1:0]      issSrc2_i = '0;
  logic [LANES*2-1:0]          issSrcVld_i = '0;
  logic [LANES*PAY_W-1:0]      issPay_i = '0;
  logic                        issReady_o;
  logic [2*LANES*TAG_W-1:0]    prfAddr_o;
  logic [2*LANES*DATA_W-1:0]   prfData_i;
  logic [LANES-1:0]            bypValid_i = '0;
  logic [LANES*TAG_W-1:0]      bypTag_i = '0;
  logic [LANES*DATA_W-1:0]     bypData_i = '0;
  logic [LANES-1:0]            exValid_o;
  logic [LANES*DATA_W-1:0]     exSrc1_o;
  logic [LANES*DATA_W-1:0]     exSrc2_o;
  logic [LANES*PAY_W-1:0]      exPay_o;
  logic                        exReady_i = 1'b1;
  logic                        flush_i = 1'b0;
  logic [15:0]                 stallCnt_o;

  rr_operand_stage #(.LANES(LANES), .TAG_W(TAG_W), .DATA_W(DATA_W), .PAY_W(PAY_W)) dut (
    .clk(clk), .reset(reset),
    .issValid_i(issValid_i), .issSrc1_i(issSrc1_i), .issSrc2_i(issSrc2_i),
    .issSrcVld_i(issSrcVld_i), .issPay_i(issPay_i), .issReady_o(issReady_o),
    .prfAddr_o(prfAddr_o), .prfData_i(prfData_i),
    .bypValid_i(bypValid_i), .bypTag_i(bypTag_i), .bypData_i(bypData_i),
    .exValid_o(exValid_o), .exSrc1_o(exSrc1_o), .exSrc2_o(exSrc2_o), .exPay_o(exPay_o),
    .exReady_i(exReady_i), .flush_i(flush_i), .stallCnt_o(stallCnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Physical register file: writebacks land at the edge, lowest lane wins a tag clash
  logic [DATA_W-1:0] regs [NREG];

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] <= 64'h1000 + 64'(i);
    regs[5]  <= 64'h11;
    regs[9]  <= 64'h5555;
    regs[20] <= 64'h20;
  end

  always @(posedge clk) begin
    for (int j = LANES - 1; j >= 0; j--)
      if (bypValid_i[j]) regs[bypTag_i[j*TAG_W +: TAG_W]] <= bypData_i[j*DATA_W +: DATA_W];
  end

  always_comb begin
    prfData_i = '0;
    for (int p = 0; p < 2*LANES; p++)
      prfData_i[p*DATA_W +: DATA_W] = regs[prfAddr_o[p*TAG_W +: TAG_W]];
  end

  // Register value as it stands once this cycle's writebacks have landed
  function automatic logic [DATA_W-1:0] newest(input logic [TAG_W-1:0] t);
    logic [DATA_W-1:0] v;
    v = regs[t];
    for (int j = LANES - 1; j >= 0; j--)
      if (bypValid_i[j] && bypTag_i[j*TAG_W +: TAG_W] == t) v = bypData_i[j*DATA_W +: DATA_W];
    return v;
  endfunction

  // Model: one waiting bundle (A) and one presented bundle (B)
  logic [LANES-1:0]  m_av;
  logic [TAG_W-1:0]  m_as1 [LANES];
  logic [TAG_W-1:0]  m_as2 [LANES];
  logic [1:0]        m_asv [LANES];
  logic [PAY_W-1:0]  m_apay [LANES];
  logic [LANES-1:0]  m_bv;
  logic [DATA_W-1:0] m_b1 [LANES];
  logic [DATA_W-1:0] m_b2 [LANES];
  logic [PAY_W-1:0]  m_bpay [LANES];
  int                m_cnt;
  logic              b_busy, b_moves, a_takes;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_av = '0;
      m_bv = '0;
      m_cnt = 0;
    end else begin
      b_busy  = (m_bv != '0);
      b_moves = !b_busy || exReady_i;
      a_takes = (m_av == '0) || b_moves;
      if (b_busy && !exReady_i && m_cnt < 65535) m_cnt++;
      if (flush_i) begin
        m_av = '0;
        m_bv = '0;
      end else begin
        if (b_moves) begin
          m_bv = m_av;
          for (int i = 0; i < LANES; i++) begin
            m_b1[i]   = m_asv[i][0] ? newest(m_as1[i]) : '0;
            m_b2[i]   = m_asv[i][1] ? newest(m_as2[i]) : '0;
            m_bpay[i] = m_apay[i];
          end
        end
        if (a_takes) begin
          m_av = issValid_i;
          for (int i = 0; i < LANES; i++) begin
            m_as1[i]  = issSrc1_i[i*TAG_W +: TAG_W];
            m_as2[i]  = issSrc2_i[i*TAG_W +: TAG_W];
            m_asv[i]  = issSrcVld_i[2*i +: 2];
            m_apay[i] = issPay_i[i*PAY_W +: PAY_W];
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("exValid", 64'(exValid_o), 64'(m_bv));
      for (int i = 0; i < LANES; i++) begin
        if (m_bv[i]) begin
          chk("exSrc1", exSrc1_o[i*DATA_W +: DATA_W], m_b1[i]);
          chk("exSrc2", exSrc2_o[i*DATA_W +: DATA_W], m_b2[i]);
          chk("exPay", 64'(exPay_o[i*PAY_W +: PAY_W]), 64'(m_bpay[i]));
        end
      end
      chk("issReady", 64'(issReady_o), 64'((m_av == '0) || (m_bv == '0) || exReady_i));
      chk("stallCnt", 64'(stallCnt_o), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issValid_i = '0;
    bypValid_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic issue0(input logic [TAG_W-1:0] t1, input logic [1:0] vld, input logic [PAY_W-1:0] pay);
    issValid_i = 4'b0001;
    issSrc1_i = '0;
    issSrc2_i = '0;
    issSrc1_i[TAG_W-1:0] = t1;
    issSrcVld_i = '0;
    issSrcVld_i[1:0] = vld;
    issPay_i = '0;
    issPay_i[PAY_W-1:0] = pay;
  endtask

  task automatic issue_all(input logic [PAY_W-1:0] pay);
    issValid_i = '1;
    issSrcVld_i = '0;
    for (int i = 0; i < LANES; i++) issPay_i[i*PAY_W +: PAY_W] = pay + PAY_W'(i << 16);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_exValid", 64'(exValid_o), 64'h0);
    chk("rst_issReady", 64'(issReady_o), 64'h1);
    chk("rst_stallCnt", 64'(stallCnt_o), 64'h0);

    // Basic path
    tick(); issue0(7'd5, 2'b01, 32'hCAFE);
    tick(); clr();
    tick();
    @(negedge clk);
    chk("basic_valid", 64'(exValid_o), 64'h1);
    chk("basic_src1", exSrc1_o[63:0], 64'h11);
    chk("basic_src2", exSrc2_o[63:0], 64'h0);

    // Same-cycle bypass from lane 2, then lowest of lanes 1/3
    tick(); issue0(7'd9, 2'b01, 32'h1);
    tick(); clr(); bypValid_i = 4'b0100;
    bypTag_i[2*TAG_W +: TAG_W] = 7'd9; bypData_i[2*DATA_W +: DATA_W] = 64'hABCD;
    tick(); clr();
    @(negedge clk);
    chk("byp_single", exSrc1_o[63:0], 64'hABCD);
    tick(); issue0(7'd9, 2'b01, 32'h2);
    tick(); clr(); bypValid_i = 4'b1010;
    bypTag_i[1*TAG_W +: TAG_W] = 7'd9; bypData_i[1*DATA_W +: DATA_W] = 64'h1111;
    bypTag_i[3*TAG_W +: TAG_W] = 7'd9; bypData_i[3*DATA_W +: DATA_W] = 64'h3333;
    tick(); clr();
    @(negedge clk);
    chk("byp_lowest", exSrc1_o[63:0], 64'h1111);

    // Backpressure from a clean counter, with a writeback to the waiting tag mid-stall
    tick(); reset = 1'b0;
    tick(); reset = 1'b1; exReady_i = 1'b0; issue0(7'd5, 2'b01, 32'h1);
    tick(); issue0(7'd20, 2'b01, 32'h2);
    tick(); clr();
    tick(); bypValid_i = 4'b0001; bypTag_i[TAG_W-1:0] = 7'd20; bypData_i[DATA_W-1:0] = 64'hBEEF;
    tick(); clr();
    tick();
    @(negedge clk);
    chk("stall_cnt3", 64'(stallCnt_o), 64'h3);
    chk("stall_issReady", 64'(issReady_o), 64'h0);
    chk("stall_valid", 64'(exValid_o), 64'h1);
    chk("stall_src1", exSrc1_o[63:0], 64'h11);
    chk("stall_pay", 64'(exPay_o[PAY_W-1:0]), 64'h1);
    tick(); exReady_i = 1'b1;
    tick();
    @(negedge clk);
    chk("stall_byp_src1", exSrc1_o[63:0], 64'hBEEF);
    chk("stall_byp_pay", 64'(exPay_o[PAY_W-1:0]), 64'h2);

    // Flush with both stages full and an issue presented
    tick(); exReady_i = 1'b0; issue_all(32'h3);
    tick(); issue_all(32'h4);
    tick(); flush_i = 1'b1; exReady_i = 1'b1; issue_all(32'h5);
    tick(); clr();
    @(negedge clk);
    chk("flush_valid", 64'(exValid_o), 64'h0);
    chk("flush_issReady", 64'(issReady_o), 64'h1);
    tick();
    @(negedge clk);
    chk("flush_dropped", 64'(exValid_o), 64'h0);

    // Back-to-back throughput
    for (int k = 0; k < 102; k++) begin
      tick();
      if (k < 100) issue_all(32'(k)); else clr();
      @(negedge clk);
      if (k >= 2) begin
        chk("tput_valid", 64'(exValid_o), 64'hF);
        chk("tput_order", 64'(exPay_o[PAY_W-1:0]), 64'(k - 2));
      end
    end

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      for (int i = 0; i < LANES; i++) begin
        issValid_i[i] = 1'($urandom_range(0, 1));
        issSrc1_i[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        issSrc2_i[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        issSrcVld_i[2*i +: 2] = 2'($urandom_range(0, 3));
        issPay_i[i*PAY_W +: PAY_W] = $urandom;
        bypValid_i[i] = 1'($urandom_range(0, 1));
        bypTag_i[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        bypData_i[i*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
      exReady_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 39) == 0);
    end
    tick(); clr(); exReady_i = 1'b1;
    tick();

    // Counter saturation
    tick(); reset = 1'b0;
    tick(); reset = 1'b1; exReady_i = 1'b0; issue0(7'd3, 2'b11, 32'h9);
    tick(); clr();
    repeat (65540) tick();
    @(negedge clk);
    chk("stall_sat", 64'(stallCnt_o), 64'hFFFF);
    tick(); exReady_i = 1'b1;
    tick();

    // Asynchronous reset between edges
    tick(); issue_all(32'h7);
    tick(); clr();
    tick();
    #2;
    chk("areset_pre", 64'(exValid_o), 64'hF);
    reset = 1'b0;
    #1;
    chk("areset_valid", 64'(exValid_o), 64'h0);
    chk("areset_issReady", 64'(issReady_o), 64'h1);
    tick(); reset = 1'b1;
    tick();
    @(negedge clk);
    chk("areset_after", 64'(exValid_o), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
